lcd_ram_write_ctrl: RTL and testbench

Command decoder and frame-RAM write sequencer sitting between the SPI receive buffer and the display frame RAM. Consumes 9-bit SPI words, where bit 8 is the mode bit: 0 = command, 1 = data. Interprets column/page window commands and memory-write bursts. Assembles RGB565 pixels from byte pairs and issues addressed writes to the frame RAM over a valid/ready handshake.

---
 rtl/lcd_pkg.sv | 21 ++
 rtl/lcd_window_cursor.sv | 82 ++++++++
 rtl/lcd_ram_write_ctrl.sv | 106 ++++++++++
 tb/tb_lcd_ram_write_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared opcodes, controller state encoding and frame geometry defaults for the LCD write path.
package lcd_pkg;

  localparam int unsigned WIDTH_DEF  = 320;
  localparam int unsigned HEIGHT_DEF = 240;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    StCmd,
    StCasetArg,
    StPasetArg,
    StPixHi,
    StPixLo,
    StDiscard
  } ctrl_state_t;

endpackage

// File: rtl/lcd_window_cursor.sv
// Column/page window registers, pixel cursor and incrementally maintained frame-RAM address.
module lcd_window_cursor
  import lcd_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned HEIGHT = HEIGHT_DEF,
  parameter int unsigned AW     = 17
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_col_i,
  input  logic          load_page_i,
  input  logic [15:0]   start_i,
  input  logic [15:0]   end_i,
  input  logic          reset_cursor_i,
  input  logic          advance_i,
  output logic          win_ok_o,
  output logic [AW-1:0] addr_o,
  output logic          frame_done_o
);

  localparam logic [15:0] ColMax = 16'(WIDTH - 1);
  localparam logic [15:0] RowMax = 16'(HEIGHT - 1);

  logic [15:0]   sc_q, ec_q, sp_q, ep_q;
  logic [15:0]   col_q, row_q;
  logic [AW-1:0] addr_q;
  logic          done_q;

  function automatic logic [AW-1:0] line_addr(input logic [15:0] row, input logic [15:0] col);
    return AW'(row) * AW'(WIDTH) + AW'(col);
  endfunction

  assign win_ok_o     = (sc_q <= ec_q) && (sp_q <= ep_q);
  assign addr_o       = addr_q;
  assign frame_done_o = done_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sc_q   <= '0;
      ec_q   <= ColMax;
      sp_q   <= '0;
      ep_q   <= RowMax;
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_col_i) begin
        sc_q <= start_i;
        ec_q <= (end_i > ColMax) ? ColMax : end_i;
      end
      if (load_page_i) begin
        sp_q <= start_i;
        ep_q <= (end_i > RowMax) ? RowMax : end_i;
      end
      if (reset_cursor_i) begin
        col_q  <= sc_q;
        row_q  <= sp_q;
        addr_q <= line_addr(sp_q, sc_q);
      end else if (advance_i) begin
        if (col_q == ec_q) begin
          col_q <= sc_q;
          if (row_q == ep_q) begin
            // Last pixel of the window: wrap to the window origin.
            row_q  <= sp_q;
            addr_q <= line_addr(sp_q, sc_q);
            done_q <= 1'b1;
          end else begin
            row_q  <= row_q + 16'd1;
            addr_q <= line_addr(row_q + 16'd1, sc_q);
          end
        end else begin
          col_q  <= col_q + 16'd1;
          addr_q <= addr_q + AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/lcd_ram_write_ctrl.sv
// SPI command decoder and RGB565 frame-RAM write sequencer with valid/ready output handshake.
module lcd_ram_write_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned HEIGHT = HEIGHT_DEF,
  parameter int unsigned AW     = 17
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          i_spi_valid,
  input  logic [8:0]    i_spi_word,
  output logic          o_spi_ready,
  output logic          o_ram_valid,
  input  logic          i_ram_ready,
  output logic [AW-1:0] o_ram_addr,
  output logic [15:0]   o_ram_data,
  output logic          o_frame_done
);

  ctrl_state_t state_q;
  logic [1:0]  arg_cnt_q;
  logic [23:0] arg_q;
  logic [7:0]  hi_q;
  logic [15:0] data_q;
  logic        ram_valid_q, spi_ready_q;

  logic        spi_xfer, cmd_xfer, data_xfer;
  logic [7:0]  byte_w;
  logic        load_col, load_page, reset_cursor, advance, win_ok, pix_load, ram_valid_d;

  assign byte_w    = i_spi_word[7:0];
  assign spi_xfer  = i_spi_valid && spi_ready_q;
  assign cmd_xfer  = spi_xfer && !i_spi_word[8];
  assign data_xfer = spi_xfer && i_spi_word[8];

  // The 4th argument byte commits the window together with the three buffered ones.
  assign load_col     = data_xfer && (state_q == StCasetArg) && (arg_cnt_q == 2'd3);
  assign load_page    = data_xfer && (state_q == StPasetArg) && (arg_cnt_q == 2'd3);
  assign reset_cursor = cmd_xfer && (byte_w == CMD_RAMWR);
  assign advance      = ram_valid_q && i_ram_ready;
  assign pix_load     = data_xfer && (state_q == StPixLo) && win_ok;
  assign ram_valid_d  = pix_load || (ram_valid_q && !i_ram_ready);

  lcd_window_cursor #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .AW    (AW)
  ) u_cursor (
    .clk_i         (sclk),
    .rst_ni        (rst_n),
    .load_col_i    (load_col),
    .load_page_i   (load_page),
    .start_i       ({arg_q[23:16], arg_q[15:8]}),
    .end_i         ({arg_q[7:0], byte_w}),
    .reset_cursor_i(reset_cursor),
    .advance_i     (advance),
    .win_ok_o      (win_ok),
    .addr_o        (o_ram_addr),
    .frame_done_o  (o_frame_done)
  );

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q     <= StCmd;
      arg_cnt_q   <= '0;
      arg_q       <= '0;
      hi_q        <= '0;
      data_q      <= '0;
      ram_valid_q <= 1'b0;
      spi_ready_q <= 1'b0;
    end else begin
      ram_valid_q <= ram_valid_d;
      spi_ready_q <= !ram_valid_d;
      if (pix_load) data_q <= {hi_q, byte_w};
      if (cmd_xfer) begin
        arg_cnt_q <= '0;
        case (byte_w)
          CMD_CASET: state_q <= StCasetArg;
          CMD_PASET: state_q <= StPasetArg;
          CMD_RAMWR: state_q <= StPixHi;
          default:   state_q <= StDiscard;
        endcase
      end else if (data_xfer) begin
        case (state_q)
          StCasetArg, StPasetArg: begin
            arg_q     <= {arg_q[15:0], byte_w};
            arg_cnt_q <= arg_cnt_q + 2'd1;
            if (arg_cnt_q == 2'd3) state_q <= StCmd;
          end
          StPixHi: begin
            hi_q    <= byte_w;
            state_q <= StPixLo;
          end
          StPixLo: state_q <= StPixHi;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign o_spi_ready = spi_ready_q;
  assign o_ram_valid = ram_valid_q;
  assign o_ram_data  = data_q;

endmodule

// File: tb/tb_lcd_ram_write_ctrl.sv
// Directed plus randomized stimulus against a coordinate-level model of the window/pixel rules.
module tb_lcd_ram_write_ctrl;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int AW = 17;

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_spi_valid = 1'b0;
  logic [8:0]    i_spi_word = '0;
  logic          o_spi_ready, o_ram_valid, o_frame_done;
  logic          i_ram_ready = 1'b0;
  logic [AW-1:0] o_ram_addr;
  logic [15:0]   o_ram_data;

  lcd_ram_write_ctrl #(
    .WIDTH (W),
    .HEIGHT(H),
    .AW    (AW)
  ) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .i_spi_valid (i_spi_valid),
    .i_spi_word  (i_spi_word),
    .o_spi_ready (o_spi_ready),
    .o_ram_valid (o_ram_valid),
    .i_ram_ready (i_ram_ready),
    .o_ram_addr  (o_ram_addr),
    .o_ram_data  (o_ram_data),
    .o_frame_done(o_frame_done)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: window in pixel coordinates, expected writes as a queue.
  typedef struct {
    int addr;
    int data;
    bit done;
  } wr_t;
  wr_t exp_q[$];

  int         m_mode;  // 0 discard, 1 column args, 2 page args, 3 pixels
  int         m_cnt;
  logic [7:0] m_args[4];
  bit         m_hi_have;
  logic [7:0] m_hi;
  int         m_sc, m_ec, m_sp, m_ep, m_col, m_row;

  function automatic void model_reset();
    m_mode = 0; m_cnt = 0; m_hi_have = 0; m_hi = '0;
    m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1; m_col = 0; m_row = 0;
  endfunction

  function automatic void model_word(input logic [8:0] w);
    int s, e;
    wr_t x;
    if (!w[8]) begin
      m_cnt = 0;
      m_hi_have = 0;
      case (w[7:0])
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_col = m_sc; m_row = m_sp; end
        default: m_mode = 0;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_args[m_cnt] = w[7:0];
      m_cnt++;
      if (m_cnt == 4) begin
        s = m_args[0] * 256 + m_args[1];
        e = m_args[2] * 256 + m_args[3];
        if (m_mode == 1) begin m_sc = s; m_ec = (e > W - 1) ? W - 1 : e; end
        else begin m_sp = s; m_ep = (e > H - 1) ? H - 1 : e; end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_hi_have) begin
        m_hi = w[7:0];
        m_hi_have = 1;
      end else begin
        m_hi_have = 0;
        if (m_sc <= m_ec && m_sp <= m_ep) begin
          x.addr = m_row * W + m_col;
          x.data = {m_hi, w[7:0]};
          x.done = (m_col == m_ec) && (m_row == m_ep);
          exp_q.push_back(x);
          if (m_col == m_ec) begin
            m_col = m_sc;
            m_row = (m_row == m_ep) ? m_sp : m_row + 1;
          end else m_col++;
        end
      end
    end
  endfunction

  // RAM-side monitor: drives ready, checks every presented write and the done pulse.
  int  rdy_mode = 1;  // 0 stall, 1 always ready, 2 random
  bit  in_reset = 1;
  bit  done_exp = 0;
  int  writes_seen = 0;
  int  done_seen = 0;
  int  seen_addr[$];

  always @(negedge sclk) begin
    case (rdy_mode)
      0:       i_ram_ready = 1'b0;
      1:       i_ram_ready = 1'b1;
      default: i_ram_ready = 1'($urandom_range(0, 1));
    endcase
    if (in_reset) begin
      done_exp = 0;
    end else begin
      check_eq("frame_done", 32'(o_frame_done), 32'(done_exp));
      if (o_frame_done) done_seen++;
      done_exp = 0;
      if (o_ram_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", 32'(o_ram_valid), 32'd0);
        end else begin
          check_eq("ram_addr", 32'(o_ram_addr), 32'(exp_q[0].addr));
          check_eq("ram_data", 32'(o_ram_data), 32'(exp_q[0].data));
          if (i_ram_ready) begin
            done_exp = exp_q[0].done;
            void'(exp_q.pop_front());
            writes_seen++;
            seen_addr.push_back(int'(o_ram_addr));
          end
        end
      end
    end
  end

  task automatic send(input logic [8:0] w);
    int n = 0;
    @(negedge sclk);
    while (!o_spi_ready && n < 200) begin
      @(negedge sclk);
      n++;
    end
    if (!o_spi_ready) begin
      check_eq("spi_ready_timeout", 32'(o_spi_ready), 32'd1);
    end else begin
      i_spi_valid = 1'b1;
      i_spi_word  = w;
      model_word(w);
      @(posedge sclk);
      #1 i_spi_valid = 1'b0;
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    send({1'b0, b});
  endtask

  task automatic dat(input logic [7:0] b);
    send({1'b1, b});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_ram_valid) && n < 2000) begin
      @(negedge sclk);
      n++;
    end
    repeat (2) @(negedge sclk);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  int base, dbase;

  initial begin
    model_reset();
    repeat (3) @(negedge sclk);
    check_eq("rst_spi_ready", 32'(o_spi_ready), 32'd0);
    check_eq("rst_ram_valid", 32'(o_ram_valid), 32'd0);
    check_eq("rst_ram_addr", 32'(o_ram_addr), 32'd0);
    check_eq("rst_ram_data", 32'(o_ram_data), 32'd0);
    check_eq("rst_frame_done", 32'(o_frame_done), 32'd0);
    rst_n = 1'b1;
    @(negedge sclk);
    check_eq("post_rst_spi_ready", 32'(o_spi_ready), 32'd1);
    in_reset = 0;

    // Default window, two pixels.
    cmd(8'h2C); dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0);
    drain();
    check_eq("t1_addr0", 32'(seen_addr[0]), 32'd0);
    check_eq("t1_addr1", 32'(seen_addr[1]), 32'd1);

    // Held write: ready low for 4 cycles.
    rdy_mode = 0;
    dat(8'hAB); dat(8'hCD);
    repeat (4) begin
      @(negedge sclk);
      check_eq("stall_spi_ready", 32'(o_spi_ready), 32'd0);
      check_eq("stall_ram_valid", 32'(o_ram_valid), 32'd1);
    end
    base = writes_seen;
    rdy_mode = 1;
    drain();
    check_eq("stall_one_write", 32'(writes_seen - base), 32'd1);

    // Aborted column window leaves the default in place.
    cmd(8'h2A); dat(8'h00); dat(8'h05);
    base = writes_seen;
    cmd(8'h2C); dat(8'h12); dat(8'h34);
    drain();
    check_eq("partial_caset_addr", 32'(seen_addr[base]), 32'd0);

    // 2x2 window, fifth pixel wraps.
    cmd(8'h2A); dat(8'h00); dat(8'd10); dat(8'h00); dat(8'd11);
    cmd(8'h2B); dat(8'h00); dat(8'd5); dat(8'h00); dat(8'd6);
    base = writes_seen; dbase = done_seen;
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) begin dat(8'(i)); dat(8'(8'h40 + i)); end
    drain();
    check_eq("win_a0", 32'(seen_addr[base]), 32'd1610);
    check_eq("win_a1", 32'(seen_addr[base + 1]), 32'd1611);
    check_eq("win_a2", 32'(seen_addr[base + 2]), 32'd1930);
    check_eq("win_a3", 32'(seen_addr[base + 3]), 32'd1931);
    check_eq("win_a4", 32'(seen_addr[base + 4]), 32'd1610);
    check_eq("win_done_count", 32'(done_seen - dbase), 32'd1);

    // EC 511 clamps to 319 on a single-row window.
    cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h01); dat(8'hFF);
    cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00);
    base = writes_seen; dbase = done_seen;
    cmd(8'h2C);
    for (int i = 0; i < 321; i++) begin dat(8'(i >> 8)); dat(8'(i)); end
    drain();
    check_eq("clamp_last_col", 32'(seen_addr[base + 319]), 32'd319);
    check_eq("clamp_wrap", 32'(seen_addr[base + 320]), 32'd0);
    check_eq("clamp_done_count", 32'(done_seen - dbase), 32'd1);

    // Reversed window discards pixels.
    cmd(8'h2A); dat(8'h00); dat(8'd20); dat(8'h00); dat(8'd10);
    base = writes_seen;
    cmd(8'h2C); dat(8'h11); dat(8'h22); dat(8'h33); dat(8'h44);
    drain();
    check_eq("reversed_no_write", 32'(writes_seen - base), 32'd0);

    // Reset while a write is pending.
    cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h03);
    rdy_mode = 0;
    cmd(8'h2C); dat(8'hDE); dat(8'hAD);
    @(negedge sclk);
    check_eq("pre_rst_valid", 32'(o_ram_valid), 32'd1);
    in_reset = 1;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge sclk);
    check_eq("mid_rst_valid", 32'(o_ram_valid), 32'd0);
    check_eq("mid_rst_spi_ready", 32'(o_spi_ready), 32'd0);
    rst_n = 1'b1;
    rdy_mode = 1;
    @(negedge sclk);
    check_eq("after_rst_spi_ready", 32'(o_spi_ready), 32'd1);
    in_reset = 0;
    base = writes_seen;
    dat(8'h01); dat(8'h02); dat(8'h03); dat(8'h04);
    drain();
    check_eq("after_rst_discard", 32'(writes_seen - base), 32'd0);

    // Randomized command/data mix with random RAM backpressure.
    rdy_mode = 2;
    for (int it = 0; it < 60; it++) begin
      int op, nb;
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          cmd(op == 0 ? 8'h2A : 8'h2B);
          dat(8'h00); dat(8'($urandom_range(0, 12)));
          if ($urandom_range(0, 4) == 0) begin dat(8'h01); dat(8'hFF); end
          else begin dat(8'h00); dat(8'($urandom_range(0, 16))); end
        end
        2: begin
          cmd($urandom_range(0, 1) ? 8'h2A : 8'h2B);
          nb = $urandom_range(0, 3);
          for (int k = 0; k < nb; k++) dat(8'($urandom_range(0, 30)));
        end
        3: begin
          cmd($urandom_range(0, 1) ? 8'h00 : 8'h5A);
          nb = $urandom_range(0, 4);
          for (int k = 0; k < nb; k++) dat(8'($urandom));
        end
        default: begin
          cmd(8'h2C);
          nb = $urandom_range(0, 24);
          for (int k = 0; k < nb; k++) dat(8'($urandom));
        end
      endcase
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
